mc_alu_ctrl: RTL and testbench
==============================

Name: mc_alu_ctrl

Overview:
- Multicycle control FSM for the CPU core; the initiator side of the ALU interface.
- Decodes opcode/funct from the instruction register and sequences datapath enables.
- Drives the 3-bit ALU operation code and consumes the ALU's zero and overflow flags for branches and overflow traps.
- Also handshakes with the unified instruction/data memory.

Parameters:
- OVF_TRAP, 1, 1 = suppress writeback and pulse exc on signed overflow (add/sub/addi); 0 = ignore overflow.
- ILLEGAL_TRAP, 1, 1 = unknown opcode/funct pulses exc; 0 = treated as NOP.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from the current cycle
- overflow  in  1  ALU signed-overflow flag, combinational from the current cycle
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualifies mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- reg_write  out  1  register-file write
- reg_dst  out  1  destination: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = extended imm, 11 = sext imm<<2
- ext_zero  out  1  1 = zero-extend imm (andi/ori)
- ALU_operation  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
- pc_write  out  1  PC load enable
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- exc  out  1  one-cycle trap pulse
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - rst high at a rising edge sets state to FETCH and clears ovf_q.
  - While rst is high, every output is forced to 0, including state = 0 (FETCH encoding).
  - rst mid-instruction abandons it; no write strobe is issued in the cycle after reset.
- Outputs are decoded from state. Mealy terms exist only on mem_ready, zero, and ovf_q, as stated below. All outputs default to 0.
- FETCH(0):
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ALU_operation=010.
  - When mem_ready=1: drives ir_write=1, pc_write=1, pc_source=00, then goes to DECODE.
  - Otherwise holds FETCH with mem_req held high.
- DECODE(1):
  - Drives alu_src_a=0, alu_src_b=11, ALU_operation=010 (branch target into ALUOut).
  - Dispatch: R-type (000000) -> R_EXE; lw 100011 / sw 101011 -> MEM_ADR; beq 000100 / bne 000101 -> BRANCH; addi 001000 / andi 001100 / ori 001101 -> I_EXE; j 000010 -> JUMP.
  - Anything else -> ILLEGAL.
  - An R-type with an unlisted funct also goes to ILLEGAL.
- R_EXE(2):
  - Drives alu_src_a=1, alu_src_b=00.
  - ALU_operation from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 100110 -> 011, 100111 -> 100, 101010 -> 111, 000010 -> 101 (shift amount routed by the datapath).
  - ovf_q <= overflow & OVF_TRAP & (funct is add or sub).
  - Goes to R_WB.
- R_WB(3):
  - Drives reg_dst=1, mem_to_reg=0, reg_write=~ovf_q, exc=ovf_q.
  - Goes to FETCH.
- MEM_ADR(4):
  - Drives alu_src_a=1, alu_src_b=10, ALU_operation=010.
  - Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD(5):
  - Drives mem_req=1, iord=1.
  - When mem_ready=1, goes to MEM_WB; otherwise holds.
- MEM_WB(6):
  - Drives reg_write=1, reg_dst=0, mem_to_reg=1.
  - Goes to FETCH.
- MEM_WR(7):
  - Drives mem_req=1, mem_we=1, iord=1.
  - When mem_ready=1, goes to FETCH; otherwise holds.
- BRANCH(8):
  - Drives alu_src_a=1, alu_src_b=00, ALU_operation=110, pc_source=01.
  - pc_write = (beq & zero) | (bne & ~zero).
  - Goes to FETCH.
- I_EXE(9):
  - Drives alu_src_a=1, alu_src_b=10, ext_zero = (andi | ori).
  - ALU_operation: addi 010, andi 000, ori 001.
  - ovf_q <= overflow & OVF_TRAP & addi.
  - Goes to I_WB.
- I_WB(10):
  - Drives reg_dst=0, mem_to_reg=0, reg_write=~ovf_q, exc=ovf_q.
  - Goes to FETCH.
- JUMP(11):
  - Drives pc_write=1, pc_source=10.
  - Goes to FETCH.
- ILLEGAL(12):
  - Drives exc=ILLEGAL_TRAP, no writes.
  - Goes to FETCH.
- Unused encodings 13-15: go to FETCH with all outputs 0.
- Latency with mem_ready tied high:
  - R-type, sw, addi/andi/ori: 4 cycles.
  - lw: 5 cycles.
  - beq/bne, j, illegal: 3 cycles.
  - Each low mem_ready cycle adds 1 cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- ovf_q is cleared on entry to FETCH.

Test Plan:
- rst=1 during MEM_RD of lw, mem_ready=0 -> next cycle all outputs 0 and no reg_write; after rst drops, FETCH has mem_req=1, ALU_operation=010.
- add (op 000000, funct 100000), mem_ready=1, overflow=0 -> state sequence 0,1,2,3,0; ALU_operation=010 in R_EXE; reg_write=1 and reg_dst=1 in R_WB.
- sub with overflow=1 in R_EXE, OVF_TRAP=1 -> ALU_operation=110; R_WB has reg_write=0 and exc=1 for exactly 1 cycle.
- beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH; bne with zero=1 -> pc_write=0; both return to FETCH after 3 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_req=1, iord=1 held 4 cycles; total 8 cycles; MEM_WB has mem_to_reg=1, reg_dst=0.
- opcode 111111 -> DECODE then ILLEGAL with exc=1 and no reg_write/mem_we/pc_write; back in FETCH at cycle 3.

Source files
------------

// File: rtl/mc_alu_ctrl.sv
// mc_alu_ctrl: multicycle control FSM for the CPU core.
//
// Decodes opcode/funct from the instruction register, steps through the
// fetch / decode / execute / memory / writeback sequence, drives the ALU
// operation code and datapath enables, and handshakes with the unified
// instruction/data memory. The ALU zero/overflow flags feed branch
// resolution and overflow traps.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   opcode, funct          IR[31:26], IR[5:0]
//   zero, overflow         ALU flags, combinational in the current cycle
//   mem_ready              memory access completes this cycle
//   mem_req, mem_we, iord  memory request, write strobe, address select
//   ir_write, reg_write    IR load, register-file write
//   reg_dst, mem_to_reg    destination / writeback-source selects
//   alu_src_a, alu_src_b   ALU operand selects
//   ext_zero               zero-extend immediate (andi/ori)
//   ALU_operation          3-bit ALU operation code
//   pc_write, pc_source    PC load enable and source select
//   exc                    one-cycle trap pulse
//   state                  current state, for debug
module mc_alu_ctrl #(
  parameter logic OVF_TRAP     = 1'b1,
  parameter logic ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] ALU_operation,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       exc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_R_EXE   = 4'd2,
    S_R_WB    = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_I_EXE   = 4'd9,
    S_I_WB    = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  logic   ovf_q, ovf_d;

  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SRL: funct_known = 1'b1;
      default:                        funct_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
    case (f)
      FN_ADD:  funct_alu_op = ALU_ADD;
      FN_SUB:  funct_alu_op = ALU_SUB;
      FN_AND:  funct_alu_op = ALU_AND;
      FN_OR:   funct_alu_op = ALU_OR;
      FN_XOR:  funct_alu_op = ALU_XOR;
      FN_NOR:  funct_alu_op = ALU_NOR;
      FN_SLT:  funct_alu_op = ALU_SLT;
      FN_SRL:  funct_alu_op = ALU_SRL;
      default: funct_alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    ovf_d         = ovf_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    ALU_operation = 3'b000;
    pc_write      = 1'b0;
    pc_source     = 2'b00;
    exc           = 1'b0;

    // Reset forces every output low combinationally so nothing leaks out
    // while rst is asserted, including a half-finished memory access.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req       = 1'b1;
          alu_src_b     = 2'b01;
          ALU_operation = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          alu_src_b     = 2'b11;
          ALU_operation = ALU_ADD;
          case (opcode)
            OP_RTYPE:         state_d = funct_known(funct) ? S_R_EXE : S_ILLEGAL;
            OP_LW, OP_SW:     state_d = S_MEM_ADR;
            OP_BEQ, OP_BNE:   state_d = S_BRANCH;
            OP_ADDI, OP_ANDI,
            OP_ORI:           state_d = S_I_EXE;
            OP_J:             state_d = S_JUMP;
            default:          state_d = S_ILLEGAL;
          endcase
        end
        S_R_EXE: begin
          alu_src_a     = 1'b1;
          ALU_operation = funct_alu_op(funct);
          ovf_d         = overflow & OVF_TRAP & ((funct == FN_ADD) | (funct == FN_SUB));
          state_d       = S_R_WB;
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = ~ovf_q;
          exc       = ovf_q;
          state_d   = S_FETCH;
        end
        S_MEM_ADR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'b10;
          ALU_operation = ALU_ADD;
          state_d       = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          ALU_operation = ALU_SUB;
          pc_source     = 2'b01;
          pc_write      = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
          state_d       = S_FETCH;
        end
        S_I_EXE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_zero  = (opcode == OP_ANDI) | (opcode == OP_ORI);
          case (opcode)
            OP_ANDI: ALU_operation = ALU_AND;
            OP_ORI:  ALU_operation = ALU_OR;
            default: ALU_operation = ALU_ADD;
          endcase
          ovf_d   = overflow & OVF_TRAP & (opcode == OP_ADDI);
          state_d = S_I_WB;
        end
        S_I_WB: begin
          reg_write = ~ovf_q;
          exc       = ovf_q;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          state_d   = S_FETCH;
        end
        S_ILLEGAL: begin
          exc     = ILLEGAL_TRAP;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase

      // The overflow flag only lives for one instruction.
      if (state_d == S_FETCH) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_alu_ctrl.sv
module tb_mc_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic       mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_zero, pc_write, exc;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] ALU_operation;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];

  mc_alu_ctrl #(.OVF_TRAP(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .ALU_operation(ALU_operation),
    .pc_write(pc_write), .pc_source(pc_source), .exc(exc), .state(state)
  );

  always #5 clk = ~clk;

  wire [21:0] obs = {state, mem_req, mem_we, iord, ir_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, ext_zero, ALU_operation,
                     pc_write, pc_source, exc};

  // Expected output vector, fields in the same order as obs.
  function automatic logic [21:0] v(
    input logic [3:0] st, input logic mreq, input logic mwe, input logic io,
    input logic irw, input logic rw, input logic rdst, input logic m2r,
    input logic asa, input logic [1:0] asb, input logic ez, input logic [2:0] aop,
    input logic pcw, input logic [1:0] pcs, input logic ex);
    v = {st, mreq, mwe, io, irw, rw, rdst, m2r, asa, asb, ez, aop, pcw, pcs, ex};
  endfunction

  task automatic chk(input string tag);
    logic [21:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic ov, input logic rdy,
                      input logic [21:0] e, input string tag);
    rst = r; opcode = op; funct = fn; zero = z; overflow = ov; mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] ZERO, F_RDY, F_WAIT, DEC, MADR, MRD, MWR, ILL;
    ZERO   = '0;
    F_RDY  = v(4'd0, 1,0,0,1,0,0,0, 0,2'b01,0,3'b010, 1,2'b00,0);
    F_WAIT = v(4'd0, 1,0,0,0,0,0,0, 0,2'b01,0,3'b010, 0,2'b00,0);
    DEC    = v(4'd1, 0,0,0,0,0,0,0, 0,2'b11,0,3'b010, 0,2'b00,0);
    MADR   = v(4'd4, 0,0,0,0,0,0,0, 1,2'b10,0,3'b010, 0,2'b00,0);
    MRD    = v(4'd5, 1,0,1,0,0,0,0, 0,2'b00,0,3'b000, 0,2'b00,0);
    MWR    = v(4'd7, 1,1,1,0,0,0,0, 0,2'b00,0,3'b000, 0,2'b00,0);
    ILL    = v(4'd12,0,0,0,0,0,0,0, 0,2'b00,0,3'b000, 0,2'b00,1);

    // Reset holds everything at zero even with mem_ready high.
    step(1, 6'b000000, 6'b100000, 0, 0, 1, ZERO, "rst_a");
    step(1, 6'b000000, 6'b100000, 0, 0, 1, ZERO, "rst_b");

    // add, no overflow: 0,1,2,3 then back to 0.
    step(0, 6'b000000, 6'b100000, 0, 0, 1, F_RDY, "add_fetch");
    step(0, 6'b000000, 6'b100000, 0, 0, 1, DEC, "add_dec");
    step(0, 6'b000000, 6'b100000, 0, 0, 1,
         v(4'd2, 0,0,0,0,0,0,0, 1,2'b00,0,3'b010, 0,2'b00,0), "add_exe");
    step(0, 6'b000000, 6'b100000, 0, 0, 1,
         v(4'd3, 0,0,0,0,1,1,0, 0,2'b00,0,3'b000, 0,2'b00,0), "add_wb");

    // sub with overflow: writeback suppressed, one-cycle exc.
    step(0, 6'b000000, 6'b100010, 0, 0, 1, F_RDY, "sub_fetch");
    step(0, 6'b000000, 6'b100010, 0, 0, 1, DEC, "sub_dec");
    step(0, 6'b000000, 6'b100010, 0, 1, 1,
         v(4'd2, 0,0,0,0,0,0,0, 1,2'b00,0,3'b110, 0,2'b00,0), "sub_exe");
    step(0, 6'b000000, 6'b100010, 0, 0, 1,
         v(4'd3, 0,0,0,0,0,1,0, 0,2'b00,0,3'b000, 0,2'b00,1), "sub_wb_trap");

    // beq taken, then bne not taken with zero=1.
    step(0, 6'b000100, 6'b000000, 1, 0, 1, F_RDY, "beq_fetch_no_exc");
    step(0, 6'b000100, 6'b000000, 1, 0, 1, DEC, "beq_dec");
    step(0, 6'b000100, 6'b000000, 1, 0, 1,
         v(4'd8, 0,0,0,0,0,0,0, 1,2'b00,0,3'b110, 1,2'b01,0), "beq_taken");
    step(0, 6'b000101, 6'b000000, 1, 0, 1, F_RDY, "bne_fetch");
    step(0, 6'b000101, 6'b000000, 1, 0, 1, DEC, "bne_dec");
    step(0, 6'b000101, 6'b000000, 1, 0, 1,
         v(4'd8, 0,0,0,0,0,0,0, 1,2'b00,0,3'b110, 0,2'b01,0), "bne_not_taken");

    // lw with three wait cycles in MEM_RD: 8 cycles total.
    step(0, 6'b100011, 6'b000000, 0, 0, 1, F_RDY, "lw_fetch");
    step(0, 6'b100011, 6'b000000, 0, 0, 1, DEC, "lw_dec");
    step(0, 6'b100011, 6'b000000, 0, 0, 1, MADR, "lw_adr");
    step(0, 6'b100011, 6'b000000, 0, 0, 0, MRD, "lw_rd_wait1");
    step(0, 6'b100011, 6'b000000, 0, 0, 0, MRD, "lw_rd_wait2");
    step(0, 6'b100011, 6'b000000, 0, 0, 0, MRD, "lw_rd_wait3");
    step(0, 6'b100011, 6'b000000, 0, 0, 1, MRD, "lw_rd_done");
    step(0, 6'b100011, 6'b000000, 0, 0, 1,
         v(4'd6, 0,0,0,0,1,0,1, 0,2'b00,0,3'b000, 0,2'b00,0), "lw_wb");

    // Unknown opcode traps and returns to FETCH on cycle 3.
    step(0, 6'b111111, 6'b000000, 0, 0, 1, F_RDY, "ill_fetch");
    step(0, 6'b111111, 6'b000000, 0, 0, 1, DEC, "ill_dec");
    step(0, 6'b111111, 6'b000000, 0, 0, 1, ILL, "ill_exc");

    // sw with one wait cycle.
    step(0, 6'b101011, 6'b000000, 0, 0, 1, F_RDY, "sw_fetch");
    step(0, 6'b101011, 6'b000000, 0, 0, 1, DEC, "sw_dec");
    step(0, 6'b101011, 6'b000000, 0, 0, 1, MADR, "sw_adr");
    step(0, 6'b101011, 6'b000000, 0, 0, 0, MWR, "sw_wr_wait");
    step(0, 6'b101011, 6'b000000, 0, 0, 1, MWR, "sw_wr_done");

    // andi: zero-extended immediate, AND op; overflow ignored.
    step(0, 6'b001100, 6'b000000, 0, 1, 1, F_RDY, "andi_fetch");
    step(0, 6'b001100, 6'b000000, 0, 1, 1, DEC, "andi_dec");
    step(0, 6'b001100, 6'b000000, 0, 1, 1,
         v(4'd9, 0,0,0,0,0,0,0, 1,2'b10,1,3'b000, 0,2'b00,0), "andi_exe");
    step(0, 6'b001100, 6'b000000, 0, 0, 1,
         v(4'd10,0,0,0,0,1,0,0, 0,2'b00,0,3'b000, 0,2'b00,0), "andi_wb");

    // addi with overflow traps.
    step(0, 6'b001000, 6'b000000, 0, 0, 1, F_RDY, "addi_fetch");
    step(0, 6'b001000, 6'b000000, 0, 0, 1, DEC, "addi_dec");
    step(0, 6'b001000, 6'b000000, 0, 1, 1,
         v(4'd9, 0,0,0,0,0,0,0, 1,2'b10,0,3'b010, 0,2'b00,0), "addi_exe");
    step(0, 6'b001000, 6'b000000, 0, 0, 1,
         v(4'd10,0,0,0,0,0,0,0, 0,2'b00,0,3'b000, 0,2'b00,1), "addi_wb_trap");

    // j, with a fetch wait cycle first.
    step(0, 6'b000010, 6'b000000, 0, 0, 0, F_WAIT, "j_fetch_wait");
    step(0, 6'b000010, 6'b000000, 0, 0, 1, F_RDY, "j_fetch");
    step(0, 6'b000010, 6'b000000, 0, 0, 1, DEC, "j_dec");
    step(0, 6'b000010, 6'b000000, 0, 0, 1,
         v(4'd11,0,0,0,0,0,0,0, 0,2'b00,0,3'b000, 1,2'b10,0), "j_jump");

    // R-type with an unlisted funct is illegal.
    step(0, 6'b000000, 6'b111111, 0, 0, 1, F_RDY, "rbad_fetch");
    step(0, 6'b000000, 6'b111111, 0, 0, 1, DEC, "rbad_dec");
    step(0, 6'b000000, 6'b111111, 0, 0, 1, ILL, "rbad_exc");

    // Reset in the middle of a stalled lw.
    step(0, 6'b100011, 6'b000000, 0, 0, 1, F_RDY, "rlw_fetch");
    step(0, 6'b100011, 6'b000000, 0, 0, 1, DEC, "rlw_dec");
    step(0, 6'b100011, 6'b000000, 0, 0, 1, MADR, "rlw_adr");
    step(0, 6'b100011, 6'b000000, 0, 0, 0, MRD, "rlw_rd");
    step(1, 6'b100011, 6'b000000, 0, 0, 0, ZERO, "rlw_rst");
    step(0, 6'b100011, 6'b000000, 0, 0, 0, F_WAIT, "rlw_post_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
